// File: rtl/i2c_master_core.sv
`timescale 1ns/1ps
// Free-running I2C write master: idle, START, address byte, WR_BYTES data bytes, STOP, repeat.
// SCL is driven push-pull; SDA is open-drain and relies on an external pull-up.
module i2c_master_core #(
    parameter int QTR      = 16,
    parameter int WR_BYTES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] mst_dfifo,
    output logic       scl,
    inout  wire        sda
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_STOP  = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DATA  = 3'd4,
        ST_ACK   = 3'd5
    } state_t;

    localparam int CW = $clog2(4 * QTR);
    localparam int BW = (WR_BYTES < 1) ? 1 : $clog2(WR_BYTES + 1);
    localparam logic [CW-1:0] C_CHG  = CW'(QTR);
    localparam logic [CW-1:0] C_RISE = CW'(2 * QTR);
    localparam logic [CW-1:0] C_SMP  = CW'(3 * QTR);
    localparam logic [CW-1:0] C_END  = CW'(4 * QTR - 1);

    state_t          state_q, state_d, mst_fsm;
    logic [CW-1:0]   c_q, c_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d, bit_cnt;
    logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            sda_oe_q, sda_oe_d;
    logic            scl_q, scl_d;
    logic            ack_q, ack_d;
    logic            sda_chg, bit_end;

    assign mst_fsm = state_q;
    assign bit_cnt = bit_cnt_q;
    assign sda_chg = (c_q == C_CHG);
    assign bit_end = (c_q == C_END);
    assign scl     = scl_q;
    assign sda     = sda_oe_q ? 1'b0 : 1'bz;

    always_comb begin
        state_d    = state_q;
        c_d        = bit_end ? '0 : c_q + CW'(1);
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        sda_oe_d   = sda_oe_q;
        ack_d      = ack_q;
        case (mst_fsm)
            ST_IDLE: begin
                sda_oe_d = 1'b0;
                if (bit_end) state_d = ST_START;
            end
            ST_START: begin
                // SDA falls mid SCL-high: the START condition
                if (c_d == C_RISE) sda_oe_d = 1'b1;
                if (bit_end) state_d = ST_ADDR;
            end
            ST_ADDR, ST_DATA: begin
                if (c_q == '0 && bit_cnt == 3'd0) shift_d = mst_dfifo;
                if (sda_chg) sda_oe_d = ~shift_q[~bit_cnt];
                if (bit_end) begin
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_d  = ST_ACK;
                        sda_oe_d = 1'b0;
                    end
                end
            end
            ST_ACK: begin
                sda_oe_d = 1'b0;
                if (c_q == C_SMP) ack_d = (sda == 1'b0);
                if (bit_end) begin
                    if (ack_q && byte_cnt_q < BW'(WR_BYTES)) begin
                        state_d    = ST_DATA;
                        byte_cnt_d = byte_cnt_q + BW'(1);
                    end else begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // SDA low while SCL is low, then released mid SCL-high: the STOP condition
                if (sda_chg) sda_oe_d = 1'b1;
                if (c_d == C_SMP) sda_oe_d = 1'b0;
                if (bit_end) begin
                    state_d    = ST_IDLE;
                    byte_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        scl_d = (state_d == ST_IDLE) || (state_d == ST_START) || (c_d >= C_RISE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            c_q        <= '0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
            sda_oe_q   <= 1'b0;
            scl_q      <= 1'b1;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            sda_oe_q   <= sda_oe_d;
            scl_q      <= scl_d;
            ack_q      <= ack_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_i2c_master_core.sv
`timescale 1ns/1ps
// Bench for i2c_master_core: a slave model acks bytes, a monitor matches observed bus
// events (state changes, START/STOP, SCL-rise data bits, spacing in clocks) against a queue.
module tb_i2c_master_core;

    localparam int QTR = 16;

    logic       clk;
    logic       rstn;
    logic [7:0] mst_dfifo;
    logic       scl;
    wire        sda;
    logic       slave_pull;
    logic       ack_en;
    logic       mon_en;
    int         cyc;
    int         last_cyc;
    int         errors;
    int         checks;

    string nm_q[$];
    int    code_q[$];
    int    dmin_q[$];
    int    dmax_q[$];

    pullup (sda);
    assign sda = slave_pull ? 1'b0 : 1'bz;

    i2c_master_core #(.QTR(QTR), .WR_BYTES(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .mst_dfifo (mst_dfifo),
        .scl       (scl),
        .sda       (sda)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, got, exp);
        end
    endtask

    task automatic push(input string nm, input int code, input int dmin, input int dmax);
        nm_q.push_back(nm);
        code_q.push_back(code);
        dmin_q.push_back(dmin);
        dmax_q.push_back(dmax);
    endtask

    task automatic push_byte(input string nm, input logic [7:0] b);
        for (int i = 7; i >= 0; i--)
            push($sformatf("%s_bit%0d", nm, 7 - i), int'(b[i]), (i == 7) ? 32 : 64, (i == 7) ? 32 : 64);
    endtask

    // Event codes: 0/1 SDA at SCL rise, 10+state on state change, 20 START, 21 STOP.
    task automatic push_frame(input logic [7:0] a, input logic [7:0] d1, input logic [7:0] d2, input bit nack);
        push("st_addr", 13, 32, 32);
        push_byte("addr", a);
        push("st_ack", 15, 32, 32);
        if (nack) begin
            push("nack_bit", 1, 32, 32);
        end else begin
            push("ack_bit", 0, 32, 32);
            push("st_data", 14, 32, 32);
            push_byte("data1", d1);
            push("st_ack", 15, 32, 32);
            push("ack_bit", 0, 32, 32);
            push("st_data", 14, 32, 32);
            push_byte("data2", d2);
            push("st_ack", 15, 32, 32);
            push("ack_bit", 0, 32, 32);
        end
        push("st_stop", 12, 32, 32);
        push("stop_scl_rise", 0, 32, 32);
        push("stop_cond", 21, 16, 16);
        push("st_idle", 10, 16, 16);
        push("st_start", 11, 64, 64);
        push("start_cond", 20, 32, 32);
    endtask

    task automatic observe(input int code);
        int dt;
        dt = cyc - last_cyc;
        last_cyc = cyc;
        checks++;
        if (code_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got code %0d after %0d clks, required no event", code, dt);
        end else begin
            string nm;
            int ec, dmin, dmax;
            nm   = nm_q.pop_front();
            ec   = code_q.pop_front();
            dmin = dmin_q.pop_front();
            dmax = dmax_q.pop_front();
            if (code != ec || dt < dmin || dt > dmax) begin
                errors++;
                $display("FAIL %s: got code %0d after %0d clks, required code %0d after %0d..%0d clks",
                         nm, code, dt, ec, dmin, dmax);
            end
        end
    endtask

    task automatic wait_fsm(input int st, input int budget, input string nm);
        int n;
        n = 0;
        while (int'(dut.mst_fsm) != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (int'(dut.mst_fsm) != st) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, mst_fsm %0d, required %0d", nm, dut.mst_fsm, st);
        end
    endtask

    task automatic wait_drain(input int budget, input string nm);
        int n;
        n = 0;
        while (code_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (code_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: %0d events outstanding, required 0", nm, code_q.size());
        end
    endtask

    // Monitor
    initial begin
        logic ps, pd, cs, cd;
        int   pst, cst;
        ps = 1'b1;
        pd = 1'b1;
        pst = 0;
        last_cyc = 0;
        forever begin
            @(negedge clk);
            cs  = scl;
            cd  = sda;
            cst = int'(dut.mst_fsm);
            if (!rstn || !mon_en) begin
                last_cyc = cyc;
            end else begin
                if (cst != pst) observe(10 + cst);
                if (ps && cs && pd && !cd) observe(20);
                else if (ps && cs && !pd && cd) observe(21);
                if (!ps && cs) observe(int'(cd));
            end
            ps  = cs;
            pd  = cd;
            pst = cst;
        end
    end

    // Slave: pulls SDA low from the ACK bit's sda_chg until the next sda_chg.
    initial begin
        slave_pull = 1'b0;
        forever begin
            @(posedge clk);
            if (!rstn) slave_pull = 1'b0;
            else if (dut.sda_chg) slave_pull = ack_en && (int'(dut.mst_fsm) == 5);
        end
    end

    // Byte source: next byte presented after the SCL rise of bit 7.
    initial begin
        logic ps2;
        ps2 = 1'b1;
        forever begin
            @(negedge clk);
            if (rstn && !ps2 && scl && dut.bit_cnt == 3'd7 &&
                (int'(dut.mst_fsm) == 3 || int'(dut.mst_fsm) == 4))
                mst_dfifo = mst_dfifo + 8'd2;
            ps2 = scl;
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        errors    = 0;
        checks    = 0;
        mon_en    = 1'b0;
        ack_en    = 1'b1;
        rstn      = 1'b0;
        mst_dfifo = 8'h5B;
        repeat (3) @(negedge clk);
        #1;
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        check("rst_fsm", dut.mst_fsm, 0);
        check("rst_bit_cnt", dut.bit_cnt, 0);
        check("rst_sda_chg", dut.sda_chg, 0);

        push("st_start", 11, 62, 66);
        push("start_cond", 20, 32, 32);
        push_frame(8'h5B, 8'h5D, 8'h5F, 1'b0);
        push_frame(8'h61, 8'h00, 8'h00, 1'b1);
        #1;
        rstn   = 1'b1;
        mon_en = 1'b1;

        wait_fsm(2, 3000, "wait_first_stop");
        ack_en = 1'b0;
        wait_fsm(0, 200, "wait_first_idle");
        wait_fsm(2, 2000, "wait_nack_stop");
        ack_en = 1'b1;
        wait_drain(500, "drain_frames");
        mon_en = 1'b0;

        // Third frame: reset while data byte 0x65 bit 3 (a 0) is driven with SCL low.
        begin
            int n;
            n = 0;
            while (!(int'(dut.mst_fsm) == 4 && dut.bit_cnt == 3'd3) && n < 3000) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (20) @(negedge clk);
        check("mid_fsm", dut.mst_fsm, 4);
        check("mid_scl_low", scl, 0);
        check("mid_sda_low", sda, 0);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_mid_scl", scl, 1);
        check("rst_mid_sda", sda, 1);
        check("rst_mid_fsm", dut.mst_fsm, 0);
        check("rst_mid_bit_cnt", dut.bit_cnt, 0);

        nm_q.delete();
        code_q.delete();
        dmin_q.delete();
        dmax_q.delete();
        push("st_start", 11, 62, 66);
        push("start_cond", 20, 32, 32);
        push("st_addr", 13, 32, 32);
        push_byte("addr3", 8'h65);
        push("st_ack", 15, 32, 32);
        push("ack_bit", 0, 32, 32);
        push("st_data", 14, 32, 32);
        repeat (3) @(negedge clk);
        #2;
        rstn   = 1'b1;
        mon_en = 1'b1;
        wait_drain(1500, "drain_after_reset");
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
